// File: rtl/sdr_pkg.sv
// sdr_pkg: shared scheduler state encoding and preamble symbols for the TX path
package sdr_pkg;
    typedef enum logic [2:0] {IDLE, PREAMBLE, PAYLOAD, DONE, ERR} sched_state_t;
    localparam logic [1:0] PREAMBLE_SYM_A = 2'b00;
    localparam logic [1:0] PREAMBLE_SYM_B = 2'b11;
endpackage

// File: rtl/qpsk_symbol_sched_if.sv
// qpsk_symbol_sched_if: valid/ready payload byte stream into the symbol scheduler
interface qpsk_symbol_sched_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    modport master(output s_data, s_valid, input s_ready);
    modport slave(input s_data, s_valid, output s_ready);
endinterface

// File: rtl/sym_timer.sv
// sym_timer: counts SPS cycles per symbol and flags the first and last cycle of each
module sym_timer #(
    parameter int SPS = 64
) (
    input  logic s_clk,
    input  logic rst_n,
    input  logic en,
    output logic stb,
    output logic last_cycle
);
    localparam int W = $clog2(SPS);
    logic [W-1:0] sps_cnt;
    always_ff @(posedge s_clk or negedge rst_n)
        if (!rst_n) sps_cnt <= '0;
        else sps_cnt <= (en && !last_cycle) ? sps_cnt + W'(1) : '0;
    assign stb        = en && (sps_cnt == '0);
    assign last_cycle = en && (sps_cnt == W'(SPS - 1));
endmodule

// File: rtl/qpsk_symbol_sched.sv
// qpsk_symbol_sched: frames payload bytes into a preamble + MSB-first dibit stream,
// each dibit held SPS cycles; an empty hold register at a byte boundary aborts the frame.
module qpsk_symbol_sched
    import sdr_pkg::*;
#(
    parameter int SPS          = 64,
    parameter int PREAMBLE_LEN = 16
) (
    input  logic                      s_clk,
    input  logic                      rst_n,
    input  logic                      i_start,
    input  logic [7:0]                i_len,
    qpsk_symbol_sched_if.slave        payload,
    output logic                      o_I,
    output logic                      o_Q,
    output logic                      o_sym_stb,
    output logic                      o_mod_en,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_err
);
    localparam int SW = $clog2(PREAMBLE_LEN > 4 ? PREAMBLE_LEN : 4);
    sched_state_t  state;
    logic [1:0]    dibit;
    logic [7:0]    shreg, hold, bytes_left, bytes_req;
    logic          hold_vld, last_cycle, hs, at_bound, load;
    logic [SW-1:0] sym_cnt;
    sym_timer #(.SPS(SPS)) u_timer (
        .s_clk(s_clk),
        .rst_n(rst_n),
        .en(o_mod_en),
        .stb(o_sym_stb),
        .last_cycle(last_cycle)
    );
    assign payload.s_ready = (state == PREAMBLE || state == PAYLOAD) && !hold_vld && (bytes_req != 8'd0);
    assign hs       = payload.s_valid && payload.s_ready;
    // end of preamble and every 4th payload dibit are byte boundaries
    assign at_bound = last_cycle && ((state == PREAMBLE && sym_cnt == SW'(PREAMBLE_LEN - 1)) ||
                                     (state == PAYLOAD && sym_cnt == SW'(3)));
    assign load     = at_bound && (bytes_left != 8'd0) && hold_vld;
    assign o_busy   = state != IDLE;
    assign o_I      = dibit[1];
    assign o_Q      = dibit[0];
    always_ff @(posedge s_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            o_mod_en   <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            dibit      <= 2'b00;
            shreg      <= 8'd0;
            hold       <= 8'd0;
            hold_vld   <= 1'b0;
            bytes_left <= 8'd0;
            bytes_req  <= 8'd0;
            sym_cnt    <= '0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            if (hs) begin
                hold      <= payload.s_data;
                bytes_req <= bytes_req - 8'd1;
            end
            // a same-cycle handshake refills hold after the boundary load took the old byte
            hold_vld <= hs || (hold_vld && !load && state != ERR);
            case (state)
                IDLE: if (i_start) begin
                    state      <= PREAMBLE;
                    o_mod_en   <= 1'b1;
                    dibit      <= PREAMBLE_SYM_A;
                    sym_cnt    <= '0;
                    bytes_left <= i_len;
                    bytes_req  <= i_len;
                end
                PREAMBLE, PAYLOAD: if (last_cycle) begin
                    if (at_bound && bytes_left == 8'd0) begin
                        state    <= DONE;
                        o_done   <= 1'b1;
                        o_mod_en <= 1'b0;
                        dibit    <= 2'b00;
                    end else if (at_bound && !hold_vld) begin
                        state    <= ERR;
                        o_err    <= 1'b1;
                        o_mod_en <= 1'b0;
                        dibit    <= 2'b00;
                    end else if (at_bound) begin
                        state      <= PAYLOAD;
                        dibit      <= hold[7:6];
                        shreg      <= {hold[5:0], 2'b00};
                        sym_cnt    <= '0;
                        bytes_left <= bytes_left - 8'd1;
                    end else begin
                        sym_cnt <= sym_cnt + SW'(1);
                        dibit   <= (state == PREAMBLE) ? (sym_cnt[0] ? PREAMBLE_SYM_A : PREAMBLE_SYM_B) : shreg[7:6];
                        shreg   <= shreg << 2;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qpsk_symbol_sched.sv
// tb_qpsk_symbol_sched: directed frames with a dibit scoreboard and a byte feeder,
// SPS=4 and PREAMBLE_LEN=2.
module tb_qpsk_symbol_sched;
    logic s_clk = 1'b0, rst_n = 1'b0, i_start = 1'b0;
    logic [7:0] i_len = 8'd0;
    logic o_I, o_Q, o_sym_stb, o_mod_en, o_busy, o_done, o_err;
    int total = 0, bad = 0, strobes = 0, hs_cnt = 0;
    logic ready_seen = 1'b0;
    logic [1:0] cur = 2'b00;
    logic [1:0] exp_q[$];
    logic [7:0] feed_q[$];

    qpsk_symbol_sched_if bus();

    qpsk_symbol_sched #(.SPS(4), .PREAMBLE_LEN(2)) dut (
        .s_clk(s_clk), .rst_n(rst_n), .i_start(i_start), .i_len(i_len), .payload(bus),
        .o_I(o_I), .o_Q(o_Q), .o_sym_stb(o_sym_stb), .o_mod_en(o_mod_en),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 s_clk = ~s_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_feed();
        bus.s_valid = feed_q.size() != 0;
        bus.s_data  = (feed_q.size() != 0) ? feed_q[0] : 8'h00;
    endtask

    task automatic push_pre();
        exp_q = '{2'b00, 2'b11};
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 3; i >= 0; i--) exp_q.push_back(b[2*i +: 2]);
    endtask

    task automatic start(input logic [7:0] len);
        strobes = 0;
        hs_cnt = 0;
        ready_seen = 1'b0;
        @(posedge s_clk); #1;
        i_start = 1'b1;
        i_len = len;
        @(posedge s_clk); #1;
        i_start = 1'b0;
        i_len = 8'd0;
    endtask

    // n counts cycles after the accepting edge; n=1 is the first preamble cycle
    task automatic wait_end(input int n0, input int want_n, input logic want_done);
        int n = n0;
        do begin
            @(negedge s_clk);
            n++;
            if (n == 1) begin
                check("start_busy", 32'(o_busy), 32'd1);
                check("start_mod_en", 32'(o_mod_en), 32'd1);
                check("start_stb", 32'(o_sym_stb), 32'd1);
            end
        end while (!(o_done || o_err) && n < 300);
        check("end_cycle", 32'(n), 32'(want_n));
        check("done", 32'(o_done), 32'(want_done));
        check("err", 32'(o_err), 32'(!want_done));
        check("leftover_syms", 32'(exp_q.size()), 32'd0);
        @(negedge s_clk);
        check("busy_after", 32'(o_busy), 32'd0);
        check("pulse_len", 32'(o_done | o_err), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_iq"}, 32'({o_I, o_Q}), 32'd0);
        check({tag, "_stb"}, 32'(o_sym_stb), 32'd0);
        check({tag, "_mod_en"}, 32'(o_mod_en), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
        check({tag, "_err"}, 32'(o_err), 32'd0);
        check({tag, "_ready"}, 32'(bus.s_ready), 32'd0);
    endtask

    // symbol monitor: scoreboard pop on each strobe, dibit must hold in between
    always @(negedge s_clk) if (rst_n) begin
        if (bus.s_ready) ready_seen = 1'b1;
        if (o_sym_stb) begin
            strobes++;
            if (exp_q.size() == 0) check("sym_extra", 32'd1, 32'd0);
            else check("sym", 32'({o_I, o_Q}), 32'(exp_q.pop_front()));
            cur = {o_I, o_Q};
        end else if (o_mod_en) check("sym_hold", 32'({o_I, o_Q}), 32'(cur));
        else check("iq_idle", 32'({o_I, o_Q}), 32'd0);
        check("mod_en_gap", 32'(o_mod_en), 32'(o_busy && !o_done && !o_err));
    end

    // byte feeder: advance to the next byte after each handshake edge
    always @(negedge s_clk) if (rst_n && bus.s_valid && bus.s_ready) begin
        @(posedge s_clk); #1;
        if (feed_q.size() != 0) void'(feed_q.pop_front());
        hs_cnt++;
        drive_feed();
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data = 8'h00;
        repeat (3) @(negedge s_clk);
        check_quiet("reset");
        rst_n = 1'b1;

        feed_q = '{8'hB4}; drive_feed(); push_pre(); push_byte(8'hB4);
        start(8'd1);
        wait_end(0, 25, 1'b1);
        check("single_strobes", 32'(strobes), 32'd6);
        check("single_hs", 32'(hs_cnt), 32'd1);

        push_pre();
        start(8'd0);
        wait_end(0, 9, 1'b1);
        check("pre_only_ready", 32'(ready_seen), 32'd0);
        check("pre_only_strobes", 32'(strobes), 32'd2);

        feed_q = '{8'h1B, 8'hE4, 8'hFF}; drive_feed(); push_pre();
        push_byte(8'h1B); push_byte(8'hE4); push_byte(8'hFF);
        start(8'd3);
        wait_end(0, 57, 1'b1);
        check("stream_hs", 32'(hs_cnt), 32'd3);
        check("stream_strobes", 32'(strobes), 32'd14);

        feed_q = '{8'h55}; drive_feed(); push_pre(); push_byte(8'h55);
        start(8'd2);
        wait_end(0, 25, 1'b0);
        check("underrun_hs", 32'(hs_cnt), 32'd1);

        feed_q = '{8'hA5}; drive_feed(); push_pre(); push_byte(8'hA5);
        start(8'd1);
        repeat (10) @(posedge s_clk);
        #1 i_start = 1'b1; i_len = 8'd9;
        @(posedge s_clk);
        #1 i_start = 1'b0; i_len = 8'd0;
        wait_end(11, 25, 1'b1);

        feed_q = '{8'h12, 8'h34}; drive_feed(); push_pre(); push_byte(8'h12); push_byte(8'h34);
        start(8'd2);
        repeat (12) @(posedge s_clk);
        @(negedge s_clk);
        check("pre_reset_busy", 32'(o_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_quiet("midreset");
        exp_q.delete();
        feed_q.delete();
        drive_feed();
        @(negedge s_clk);
        rst_n = 1'b1;

        feed_q = '{8'hC3}; drive_feed(); push_pre(); push_byte(8'hC3);
        start(8'd1);
        wait_end(0, 25, 1'b1);
        check("after_reset_strobes", 32'(strobes), 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/qpsk_symbol_sched.md
# qpsk_symbol_sched

Frame-level symbol scheduler that feeds the QPSK modulator in the TX path. It accepts payload bytes over a valid/ready stream and emits a framed dibit sequence: a fixed preamble, then the payload MSB-first. Each dibit is held stable for exactly SPS `s_clk` cycles, and a one-cycle strobe marks the start of each symbol. An upstream underrun aborts the frame cleanly and reports an error instead of emitting garbage symbols.

## Interface
- `SPS`, default 64: `s_clk` cycles per symbol. Must be ≥ 2.
- `PREAMBLE_LEN`, default 16: number of preamble symbols. Must be ≥ 1.
- `s_clk` in 1: sample clock; all logic runs on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_start` in 1: frame start request; honoured only in IDLE.
- `i_len` in 8: payload length in bytes, sampled on an accepted `i_start`. 0 means preamble only.
- `s_data` in 8: payload byte.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: byte accepted on a cycle where `s_valid && s_ready`.
- `o_I`, `o_Q` out 1 each: current symbol dibit, routed to the modulator I/Q inputs.
- `o_sym_stb` out 1: high on the first cycle of every symbol.
- `o_mod_en` out 1: high while a symbol is being emitted.
- `o_busy` out 1: high in every state except IDLE.
- `o_done` out 1: one-cycle pulse when a frame completes normally.
- `o_err` out 1: one-cycle pulse on an underrun abort.

## Operation
- FSM states: IDLE, PREAMBLE, PAYLOAD, DONE, ERR.
- **IDLE**
  - `i_start` latches `i_len` into `bytes_left` and moves to PREAMBLE.
  - `sps_cnt` and `sym_cnt` are cleared.
- **PREAMBLE**
  - Symbols alternate 00, 11, 00, … starting with 00.
  - After `PREAMBLE_LEN` symbols: go to PAYLOAD if `i_len != 0`, else go to DONE.
- **Byte path**
  - A 1-entry holding register (`hold`, `hold_vld`) sits in front of an 8-bit shift register.
  - `s_ready = (PREAMBLE || PAYLOAD) && !hold_vld && (bytes_req != 0)`.
  - `bytes_req` counts bytes still to be accepted. It starts at `i_len` and decrements on each handshake.
- **PAYLOAD**
  - Dibits are emitted in the order {b7,b6}, {b5,b4}, {b3,b2}, {b1,b0}, mapped as `o_I` = first bit, `o_Q` = second bit.
  - On each byte boundary (the first symbol, and after every 4th dibit), the shift register loads from `hold` and clears `hold_vld`.
  - If `hold_vld` = 0 at a byte boundary, this is an underrun and the FSM goes to ERR.
  - After the last dibit of the last byte, the FSM goes to DONE.
- **DONE**: `o_done` = 1 for one cycle, then IDLE.
- **ERR**
  - `o_err` = 1 for one cycle, then IDLE.
  - The residual `hold` byte is discarded.
  - `s_ready` stays low in ERR.
- **Other rules**
  - `i_start` is ignored while `o_busy` = 1.
  - `s_valid` is ignored in IDLE, DONE and ERR.

## Timing
- Reset values: all outputs 0; state IDLE; all counters 0; `hold_vld` = 0.
- **Start**
  - `i_start` accepted at cycle t → `o_busy`, `o_mod_en`, `o_sym_stb` = 1 at t+1.
  - First preamble symbol 00 is presented at t+1.
- **Symbol timing**
  - `sps_cnt` runs 0..SPS-1; `o_sym_stb = o_mod_en && (sps_cnt == 0)`.
  - The dibit changes only on cycles where `sps_cnt` = 0.
- **Symbol decisions**
  - All symbol-boundary decisions (next dibit, underrun check, state change) are registered at `sps_cnt == SPS-1`.
  - Therefore a byte must be in `hold` by the cycle where the last symbol of the previous byte has `sps_cnt == SPS-1`.
  - Prefetch starts in PREAMBLE, so the first payload byte is already accepted before PAYLOAD begins.
- **Frame length**: the frame occupies `(PREAMBLE_LEN + 4*i_len) * SPS` cycles with `o_mod_en` = 1, followed by 1 cycle of DONE.
- **Underrun**: the ERR cycle immediately follows the last completed symbol. No partial symbol is ever emitted.
- **Outputs outside emission**: `o_I` and `o_Q` read 0 in IDLE, DONE and ERR.
- **Simultaneous events**: a handshake on the same cycle as a byte-boundary load is allowed. The load takes the old `hold` contents and the new byte is written into `hold`.
- **Reset mid-frame**: immediate return to reset values. No `o_done` or `o_err` pulse.

## Structure
- Shared `sdr_pkg` holds:
  - the `sched_state_t` enum;
  - the `PREAMBLE_SYM_A` = 2'b00 and `PREAMBLE_SYM_B` = 2'b11 constants.
- One natural sub-module, `sym_timer`:
  - contains the `sps_cnt` counter;
  - generates the symbol strobe and the `last_cycle` flag;
  - takes the enable and `SPS` as inputs.
- Byte holding register, shift register and FSM remain in `qpsk_symbol_sched`.

## Test plan
All scenarios use SPS=4 and PREAMBLE_LEN=2.
- **Reset**: assert `rst_n` = 0 mid-PAYLOAD → all outputs 0 immediately; the next `i_start` produces a clean frame.
- **Single byte**: `i_len` = 1, byte 0xB4 valid early → dibits 00, 11, 10, 11, 01, 00, each held 4 cycles; 6 `o_sym_stb` pulses; `o_done` at cycle 25 after start.
- **Preamble only**: `i_len` = 0 → dibits 00, 11; `s_ready` never high; `o_done` 8 cycles after the first strobe.
- **Backpressure-free stream**: `i_len` = 3, bytes 0x1B, 0xE4, 0xFF, with `s_valid` held high → exactly 3 handshakes; 12 payload dibits in MSB-first order; no gaps in `o_mod_en`.
- **Underrun**: `i_len` = 2, only 0x55 supplied → dibits 00, 11, 01, 01, 01, 01, then `o_err` pulse; `o_done` never asserted; `o_busy` low the next cycle.
- **Busy start**: `i_start` pulsed mid-frame with `i_len` = 9 → ignored; the frame length is unchanged.
